// File: rtl/fifo4_word.sv
// ---------------------------------------------------------------------------
// fifo4_word
// Four-entry word FIFO with a valid/ready handshake on both sides. It sits
// between a producer stage and the datapath consumer and absorbs up to four
// words of back-pressure.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   in_data    in   WIDTH  word offered by producer
//   in_valid   in   1      producer has a word on in_data
//   in_ready   out  1      FIFO can accept a word this cycle
//   out_data   out  WIDTH  word at head of FIFO
//   out_valid  out  1      FIFO holds at least one word
//   out_ready  in   1      consumer takes head word this cycle
//   count      out  3      words held, 0..4
//
// in_ready, out_valid and out_data are decoded combinationally from registered
// state only, so there is no path from in_valid to in_ready or from out_ready
// to out_valid. A word pushed at one edge becomes visible after that edge;
// there is no fall-through when empty.
// ---------------------------------------------------------------------------
module fifo4_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       count
);

    logic [WIDTH-1:0] entry_r [4];
    logic [1:0]       wr_ptr_r;
    logic [1:0]       rd_ptr_r;
    logic [2:0]       count_r;

    logic             push_s;
    logic             pop_s;
    logic [3:0]       load_en_s;
    logic [2:0]       count_nxt_s;

    // Handshake status decoded from the registered occupancy only.
    assign in_ready  = (count_r != 3'd4);
    assign out_valid = (count_r != 3'd0);
    assign count     = count_r;
    assign out_data  = entry_r[rd_ptr_r];

    assign push_s = in_valid & in_ready;
    assign pop_s  = out_valid & out_ready;

    // One-hot write steering: decode wr_ptr and gate it with the push strobe.
    always_comb begin
        load_en_s = 4'b0000;
        if (push_s) begin
            case (wr_ptr_r)
                2'd0:    load_en_s = 4'b0001;
                2'd1:    load_en_s = 4'b0010;
                2'd2:    load_en_s = 4'b0100;
                2'd3:    load_en_s = 4'b1000;
                default: load_en_s = 4'b0000;
            endcase
        end else begin
            load_en_s = 4'b0000;
        end
    end

    // Occupancy update: a simultaneous push and pop leaves the count as is.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 3'd1;
            2'b01:   count_nxt_s = count_r - 3'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at 2 bits, so full
    // and empty both have wr_ptr == rd_ptr and only count separates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array; popped entries are left in place and simply overwritten
    // on a later push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                entry_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load_en_s[i]) begin
                    entry_r[i] <= in_data;
                end
            end
        end
    end

endmodule
